// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes and address helpers.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte address to word address; the low two bits never select anything.
  function automatic logic [29:0] byte_to_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  // True when any byte-address bit above the RAM's reach is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int unsigned mem_aw);
    return (addr >> (mem_aw + 2)) != 32'd0;
  endfunction

  // Only FIXED and INCR are served; WRAP and the reserved code are errors.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // Address of the following beat: INCR steps one word (wrapping at 32 bits).
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst);
    return (burst == BURST_INCR) ? addr + 32'd4 : addr;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// 32-bit RAM with one byte-enabled synchronous write port and one
// asynchronous read port. Contents are never reset.
module byte_en_ram #(
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**MEM_AW];

  // Byte-lane write: only lanes whose strobe bit is set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave responder over a byte-writable RAM. Independent write
// (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) state machines; FIXED and
// INCR bursts are served, everything else answers SLVERR.
module axi_slave_ram
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned MEM_AW   = 10
) (
  input  logic                clk,
  input  logic                rstn,
  output logic                SLAVE_CLK,
  output logic                SLAVE_RSTN,
  // write address
  input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
  input  logic [31:0]         SLAVE_WR_ADDR,
  input  logic [7:0]          SLAVE_WR_ADDR_LEN,
  input  logic [1:0]          SLAVE_WR_ADDR_BURST,
  input  logic                SLAVE_WR_ADDR_VALID,
  output logic                SLAVE_WR_ADDR_READY,
  // write data
  input  logic [31:0]         SLAVE_WR_DATA,
  input  logic [3:0]          SLAVE_WR_STRB,
  input  logic                SLAVE_WR_DATA_LAST,
  input  logic                SLAVE_WR_DATA_VALID,
  output logic                SLAVE_WR_DATA_READY,
  // write response
  output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
  output logic [1:0]          SLAVE_WR_BACK_RESP,
  output logic                SLAVE_WR_BACK_VALID,
  input  logic                SLAVE_WR_BACK_READY,
  // read address
  input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
  input  logic [31:0]         SLAVE_RD_ADDR,
  input  logic [7:0]          SLAVE_RD_ADDR_LEN,
  input  logic [1:0]          SLAVE_RD_ADDR_BURST,
  input  logic                SLAVE_RD_ADDR_VALID,
  output logic                SLAVE_RD_ADDR_READY,
  // read data
  output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
  output logic [31:0]         SLAVE_RD_DATA,
  output logic [1:0]          SLAVE_RD_DATA_RESP,
  output logic                SLAVE_RD_DATA_LAST,
  output logic                SLAVE_RD_DATA_VALID,
  input  logic                SLAVE_RD_DATA_READY
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  assign SLAVE_CLK  = clk;
  assign SLAVE_RSTN = rstn;

  // Address readies stay low until one full cycle out of reset.
  logic active;

  // write side
  w_state_t    w_state, w_state_nx;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_cnt;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        w_overrun;
  logic        w_beat_err;
  logic        aw_hs, w_hs;

  // read side
  r_state_t    r_state, r_state_nx;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [1:0]  r_burst;
  logic [31:0] r_next;
  logic [31:0] r_src_addr;
  logic [1:0]  r_src_burst;
  logic        r_src_err;
  logic        ar_hs, r_hs;

  // RAM ports
  logic              ram_we;
  logic [MEM_AW-1:0] ram_waddr;
  logic [MEM_AW-1:0] ram_raddr;
  logic [31:0]       ram_rdata;

  byte_en_ram #(.MEM_AW(MEM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wstrb (SLAVE_WR_STRB),
    .waddr (ram_waddr),
    .wdata (SLAVE_WR_DATA),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Track the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rstn) active <= 1'b0;
    else       active <= 1'b1;
  end

  // ---------------------------------------------------------------- write

  assign aw_hs = SLAVE_WR_ADDR_VALID & SLAVE_WR_ADDR_READY;
  assign w_hs  = SLAVE_WR_DATA_VALID & SLAVE_WR_DATA_READY;

  // A beat errs on a bad address/burst, on LAST disagreeing with LEN, or once
  // the burst has run past LEN without LAST (it then ends only at LAST).
  assign w_beat_err = ~burst_supported(w_burst)
                    | addr_out_of_range(w_addr, MEM_AW)
                    | w_overrun
                    | (SLAVE_WR_DATA_LAST != (w_cnt == w_len));

  assign ram_we    = w_hs & ~w_beat_err;
  assign ram_waddr = MEM_AW'(byte_to_word(w_addr));

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_state_nx;
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_state_nx          = w_state;
    SLAVE_WR_ADDR_READY = 1'b0;
    SLAVE_WR_DATA_READY = 1'b0;
    SLAVE_WR_BACK_VALID = 1'b0;
    case (w_state)
      W_IDLE: begin
        SLAVE_WR_ADDR_READY = active;
        if (SLAVE_WR_ADDR_VALID && active) w_state_nx = W_DATA;
      end
      W_DATA: begin
        SLAVE_WR_DATA_READY = 1'b1;
        if (SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_LAST) w_state_nx = W_RESP;
      end
      W_RESP: begin
        SLAVE_WR_BACK_VALID = 1'b1;
        if (SLAVE_WR_BACK_READY) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write request capture, beat bookkeeping and the sticky response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_addr             <= '0;
      w_len              <= '0;
      w_cnt              <= '0;
      w_burst            <= '0;
      w_err              <= 1'b0;
      w_overrun          <= 1'b0;
      SLAVE_WR_BACK_ID   <= '0;
      SLAVE_WR_BACK_RESP <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        SLAVE_WR_BACK_ID <= SLAVE_WR_ADDR_ID;
        w_addr           <= SLAVE_WR_ADDR;
        w_len            <= SLAVE_WR_ADDR_LEN;
        w_burst          <= SLAVE_WR_ADDR_BURST;
        w_cnt            <= '0;
        w_err            <= 1'b0;
        w_overrun        <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (w_beat_err) w_err <= 1'b1;
        if (!SLAVE_WR_DATA_LAST && (w_cnt == w_len)) w_overrun <= 1'b1;
        if (SLAVE_WR_DATA_LAST)
          SLAVE_WR_BACK_RESP <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ----------------------------------------------------------------- read

  assign ar_hs = SLAVE_RD_ADDR_VALID & SLAVE_RD_ADDR_READY;
  assign r_hs  = SLAVE_RD_DATA_VALID & SLAVE_RD_DATA_READY;

  // The output register is loaded from the request itself in R_IDLE and from
  // the stepped address in R_DATA, so the RAM read port follows that choice.
  assign r_next      = next_addr(r_addr, r_burst);
  assign r_src_addr  = (r_state == R_IDLE) ? SLAVE_RD_ADDR       : r_next;
  assign r_src_burst = (r_state == R_IDLE) ? SLAVE_RD_ADDR_BURST : r_burst;
  assign r_src_err   = ~burst_supported(r_src_burst)
                     | addr_out_of_range(r_src_addr, MEM_AW);
  assign ram_raddr   = MEM_AW'(byte_to_word(r_src_addr));

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nx;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    r_state_nx          = r_state;
    SLAVE_RD_ADDR_READY = 1'b0;
    SLAVE_RD_DATA_VALID = 1'b0;
    case (r_state)
      R_IDLE: begin
        SLAVE_RD_ADDR_READY = active;
        if (SLAVE_RD_ADDR_VALID && active) r_state_nx = R_DATA;
      end
      R_DATA: begin
        SLAVE_RD_DATA_VALID = 1'b1;
        if (SLAVE_RD_DATA_READY && SLAVE_RD_DATA_LAST) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read request capture and the registered R beat (held while stalled).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr             <= '0;
      r_len              <= '0;
      r_cnt              <= '0;
      r_burst            <= '0;
      SLAVE_RD_BACK_ID   <= '0;
      SLAVE_RD_DATA      <= '0;
      SLAVE_RD_DATA_RESP <= RESP_OKAY;
      SLAVE_RD_DATA_LAST <= 1'b0;
    end else if (ar_hs) begin
      SLAVE_RD_BACK_ID   <= SLAVE_RD_ADDR_ID;
      r_addr             <= SLAVE_RD_ADDR;
      r_len              <= SLAVE_RD_ADDR_LEN;
      r_burst            <= SLAVE_RD_ADDR_BURST;
      r_cnt              <= '0;
      SLAVE_RD_DATA      <= r_src_err ? '0 : ram_rdata;
      SLAVE_RD_DATA_RESP <= r_src_err ? RESP_SLVERR : RESP_OKAY;
      SLAVE_RD_DATA_LAST <= (SLAVE_RD_ADDR_LEN == 8'd0);
    end else if (r_hs) begin
      if (SLAVE_RD_DATA_LAST) begin
        SLAVE_RD_DATA_LAST <= 1'b0;
      end else begin
        r_addr             <= r_next;
        r_cnt              <= r_cnt + 8'd1;
        SLAVE_RD_DATA      <= r_src_err ? '0 : ram_rdata;
        SLAVE_RD_DATA_RESP <= r_src_err ? RESP_SLVERR : RESP_OKAY;
        SLAVE_RD_DATA_LAST <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Randomised bench for axi_slave_ram with a word-array reference memory.
module tb_axi_slave_ram;

  localparam int unsigned IDW       = 2;
  localparam int unsigned MAW       = 10;
  localparam int unsigned MEM_WORDS = 1 << MAW;

  logic            clk, rstn, s_clk, s_rstn;
  logic [IDW-1:0]  aw_id;    logic [31:0] aw_addr; logic [7:0] aw_len; logic [1:0] aw_burst;
  logic            aw_valid, aw_ready;
  logic [31:0]     w_data;   logic [3:0]  w_strb;  logic w_last, w_valid, w_ready;
  logic [IDW-1:0]  b_id;     logic [1:0]  b_resp;  logic b_valid, b_ready;
  logic [IDW-1:0]  ar_id;    logic [31:0] ar_addr; logic [7:0] ar_len; logic [1:0] ar_burst;
  logic            ar_valid, ar_ready;
  logic [IDW-1:0]  r_id;     logic [31:0] r_data;  logic [1:0] r_resp;
  logic            r_last, r_valid, r_ready;

  axi_slave_ram #(.ID_WIDTH(IDW), .MEM_AW(MAW)) dut (
    .clk(clk), .rstn(rstn), .SLAVE_CLK(s_clk), .SLAVE_RSTN(s_rstn),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
    .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp),
    .SLAVE_WR_BACK_VALID(b_valid), .SLAVE_WR_BACK_READY(b_ready),
    .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
    .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
    .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
    .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference memory plus per-beat write payload used by do_write.
  logic [31:0] model [MEM_WORDS];
  logic [31:0] wdat  [64];
  logic [3:0]  wstb  [64];

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
    return (burst == 2'b01) ? a + 32'(4 * b) : a;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return a >= 32'(4 * MEM_WORDS);
  endfunction

  // Full write transaction; the model is updated from the burst rules first.
  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats);
    logic [1:0] exp_resp, got_resp; logic [IDW-1:0] got_id; logic [31:0] ba;
    bit ok, err;
    exp_resp = 2'b00;
    for (int b = 0; b < nbeats; b++) begin
      ba  = beat_addr(addr, burst, b);
      err = addr_bad(ba) || (burst > 2'b01) || ((b == nbeats - 1) != (b == int'(len))) || (b > int'(len));
      if (err) exp_resp = 2'b10;
      else for (int k = 0; k < 4; k++)
        if (wstb[b][k]) model[ba[MAW+1:2]][8*k +: 8] = wdat[b][8*k +: 8];
    end
    @(negedge clk);
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      ok = aw_ready; @(posedge clk); if (ok) break; @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++; $display("FAIL aw_timeout: aw_ready never 1"); aw_valid = 1'b0; return;
    end
    @(negedge clk);
    aw_valid = 1'b0;
    tests++;
    if (w_ready !== 1'b1) begin fails++; $display("FAIL w_ready_latency: got %b want 1", w_ready); end
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(3) == 0) begin w_valid = 1'b0; @(negedge clk); end
      w_valid = 1'b1; w_data = wdat[b]; w_strb = wstb[b]; w_last = (b == nbeats - 1);
      ok = 0;
      for (int n = 0; n < 50; n++) begin
        ok = w_ready; @(posedge clk); if (ok) break; @(negedge clk);
      end
      if (!ok) begin
        tests++; fails++; $display("FAIL w_timeout: beat %0d not accepted", b);
        w_valid = 1'b0; w_last = 1'b0; return;
      end
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    tests++;
    if (b_valid !== 1'b1) begin fails++; $display("FAIL b_latency: b_valid=%b want 1", b_valid); end
    if ($urandom_range(1) == 1) begin b_ready = 1'b0; @(posedge clk); @(negedge clk); end
    b_ready = 1'b1; ok = 0; got_resp = 'x; got_id = 'x;
    for (int n = 0; n < 50; n++) begin
      ok = b_valid; got_resp = b_resp; got_id = b_id; @(posedge clk); if (ok) break; @(negedge clk);
    end
    @(negedge clk);
    b_ready = 1'b0;
    if (!ok) begin tests++; fails++; $display("FAIL b_timeout: no write response"); return; end
    tests++;
    if (got_resp !== exp_resp) begin fails++; $display("FAIL b_resp: got %b want %b", got_resp, exp_resp); end
    tests++;
    if (got_id !== id) begin fails++; $display("FAIL b_id: got %0d want %0d", got_id, id); end
    tests++;
    if ({aw_ready, b_valid} !== 2'b10) begin
      fails++; $display("FAIL b_after: aw_ready,b_valid=%b want 10", {aw_ready, b_valid});
    end
  endtask

  // Full read transaction; every beat is checked against the model.
  // mode 0: ready held high, 1: ready toggles, 2: random ready.
  task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int mode);
    logic [31:0] ba, exp_data; logic [1:0] exp_resp; logic [34:0] held;
    bit ok, err, rr, stalled, done; int b;
    @(negedge clk);
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      ok = ar_ready; @(posedge clk); if (ok) break; @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++; $display("FAIL ar_timeout: ar_ready never 1"); ar_valid = 1'b0; return;
    end
    @(negedge clk);
    ar_valid = 1'b0;
    b = 0; stalled = 0; done = 0; held = '0;
    for (int c = 0; c < 4 * (int'(len) + 1) + 20 && !done; c++) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(1));
      r_ready = rr;
      if (c == 0) begin
        tests++;
        if (r_valid !== 1'b1) begin fails++; $display("FAIL r_latency: r_valid=%b want 1", r_valid); end
      end
      if (r_valid === 1'b1) begin
        if (stalled) begin
          tests++;
          if ({r_data, r_resp, r_last} !== held) begin
            fails++; $display("FAIL r_stall_stable: got %h want %h", {r_data, r_resp, r_last}, held);
          end
        end
        if (rr) begin
          ba       = beat_addr(addr, burst, b);
          err      = addr_bad(ba) || (burst > 2'b01);
          exp_data = err ? 32'h0 : model[ba[MAW+1:2]];
          exp_resp = err ? 2'b10 : 2'b00;
          tests++;
          if ({r_data, r_resp, r_last, r_id} !== {exp_data, exp_resp, b == int'(len), id}) begin
            fails++;
            $display("FAIL r_beat %0d: got data=%h resp=%b last=%b id=%0d want data=%h resp=%b last=%b id=%0d",
                     b, r_data, r_resp, r_last, r_id, exp_data, exp_resp, b == int'(len), id);
          end
          b++; stalled = 0;
          if (b == int'(len) + 1) done = 1;
        end else begin
          stalled = 1; held = {r_data, r_resp, r_last};
        end
      end
      @(posedge clk); @(negedge clk);
    end
    r_ready = 1'b0;
    tests++;
    if (!done) begin fails++; $display("FAIL r_timeout: %0d of %0d beats", b, int'(len) + 1); end
    else if (r_valid !== 1'b0) begin fails++; $display("FAIL r_after_last: r_valid=%b want 0", r_valid); end
    else if (ar_ready !== 1'b1) begin fails++; $display("FAIL r_ar_ready: got %b want 1", ar_ready); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 000000", {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last});
    end
    tests++;
    if ({b_id, b_resp, r_id, r_resp, r_data} !== '0) begin
      fails++; $display("FAIL reset_fields: got %h want 0", {b_id, b_resp, r_id, r_resp, r_data});
    end
    tests++;
    if ({s_rstn, s_clk} !== {rstn, clk}) begin
      fails++; $display("FAIL passthru: got %b want %b", {s_rstn, s_clk}, {rstn, clk});
    end
    rstn = 1'b1;
    #1;
    tests++;
    if ({aw_ready, ar_ready} !== 2'b00) begin
      fails++; $display("FAIL ready_early: got %b want 00", {aw_ready, ar_ready});
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if ({aw_ready, ar_ready, s_rstn} !== 3'b111) begin
      fails++; $display("FAIL ready_rise: got %b want 111", {aw_ready, ar_ready, s_rstn});
    end
  endtask

  // Give the low 32 words known contents for later reads.
  task automatic test_fill;
    for (int i = 0; i < 32; i++) begin wdat[i] = $urandom; wstb[i] = 4'hf; end
    do_write(2'd0, 32'h0, 8'd31, 2'b01, 32);
    do_read(2'd0, 32'h0, 8'd31, 2'b01, 0);
  endtask

  task automatic test_single;
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hf;
    do_write(2'd1, 32'h10, 8'd0, 2'b01, 1);
    do_read(2'd1, 32'h10, 8'd0, 2'b01, 0);
    tests++;
    if (model[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_model: got %h want deadbeef", model[4]); end
  endtask

  task automatic test_incr_toggle;
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hf; end
    do_write(2'd3, 32'h100, 8'd3, 2'b01, 4);
    do_read(2'd2, 32'h100, 8'd3, 2'b01, 1);
  endtask

  task automatic test_partial_strobe;
    wdat[0] = 32'h0; wstb[0] = 4'hf;
    do_write(2'd0, 32'h40, 8'd0, 2'b01, 1);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    do_write(2'd0, 32'h40, 8'd0, 2'b01, 1);
    do_read(2'd1, 32'h40, 8'd0, 2'b00, 0);
    tests++;
    if (model[16] !== 32'h00BB00DD) begin fails++; $display("FAIL strobe_model: got %h want 00bb00dd", model[16]); end
  endtask

  task automatic test_errors;
    wdat[0] = 32'h12345678; wstb[0] = 4'hf;
    do_write(2'd1, 32'h1000, 8'd0, 2'b01, 1);           // aliases word 0 if not blocked
    do_read(2'd1, 32'h1000, 8'd0, 2'b01, 0);
    do_read(2'd0, 32'h0, 8'd0, 2'b01, 0);
    wdat[0] = 32'hCAFE0001; wdat[1] = 32'hCAFE0002; wstb[0] = 4'hf; wstb[1] = 4'hf;
    do_write(2'd2, 32'h20, 8'd1, 2'b10, 2);             // WRAP
    do_read(2'd2, 32'h20, 8'd1, 2'b01, 0);
    do_read(2'd3, 32'h20, 8'd1, 2'b10, 2);
    do_read(2'd3, 32'h20, 8'd0, 2'b11, 0);
    // INCR burst running off the top of the RAM
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hf; end
    do_write(2'd0, 32'hFF8, 8'd1, 2'b01, 2);
    for (int i = 0; i < 4; i++) wdat[i] = $urandom;
    do_write(2'd1, 32'hFF8, 8'd3, 2'b01, 4);
    do_read(2'd1, 32'hFF8, 8'd3, 2'b01, 2);
    do_read(2'd2, 32'hFFFFFFFC, 8'd1, 2'b01, 0);        // 32-bit wrap back into range
  endtask

  task automatic test_early_last;
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hf; end
    do_write(2'd2, 32'h140, 8'd3, 2'b01, 2);            // LAST on beat 1
    do_read(2'd2, 32'h140, 8'd1, 2'b01, 0);
    for (int i = 0; i < 4; i++) wdat[i] = $urandom;
    do_write(2'd1, 32'h150, 8'd1, 2'b01, 3);            // LAST late
    do_read(2'd1, 32'h150, 8'd2, 2'b01, 0);
  endtask

  task automatic test_same_cycle;
    logic [31:0] old_v, new_v;
    old_v = model[24]; new_v = $urandom;
    @(negedge clk);
    aw_id = 2'd1; aw_addr = 32'h60; aw_len = 8'd0; aw_burst = 2'b01; aw_valid = 1'b1;
    w_data = new_v; w_strb = 4'hf; w_last = 1'b1; w_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    aw_valid = 1'b0;
    ar_id = 2'd2; ar_addr = 32'h60; ar_len = 8'd0; ar_burst = 2'b01; ar_valid = 1'b1;
    tests++;
    if ({w_ready, ar_ready} !== 2'b11) begin fails++; $display("FAIL same_setup: got %b want 11", {w_ready, ar_ready}); end
    @(posedge clk); @(negedge clk);
    ar_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    tests++;
    if ({r_valid, r_data, r_resp, r_last} !== {1'b1, old_v, 2'b00, 1'b1}) begin
      fails++; $display("FAIL same_read_old: got v=%b d=%h want v=1 d=%h", r_valid, r_data, old_v);
    end
    tests++;
    if ({b_valid, b_resp, b_id} !== {1'b1, 2'b00, 2'd1}) begin
      fails++; $display("FAIL same_b: got %b want 1_00_01", {b_valid, b_resp, b_id});
    end
    r_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    r_ready = 1'b0; b_ready = 1'b0;
    model[24] = new_v;
    do_read(2'd0, 32'h60, 8'd0, 2'b01, 0);
  endtask

  task automatic test_reset_mid_burst;
    int beats;
    @(negedge clk);
    ar_id = 2'd1; ar_addr = 32'h100; ar_len = 8'd3; ar_burst = 2'b01; ar_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    ar_valid = 1'b0; r_ready = 1'b1; beats = 0;
    for (int c = 0; c < 20; c++) begin
      if (r_valid === 1'b1 && beats == 2) break;
      if (r_valid === 1'b1) beats++;
      @(posedge clk); @(negedge clk);
    end
    tests++;
    if ({r_valid, r_data} !== {1'b1, model[66]}) begin
      fails++; $display("FAIL mid_beat2: got v=%b d=%h want v=1 d=%h", r_valid, r_data, model[66]);
    end
    rstn = 1'b0; r_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({r_valid, r_last, ar_ready, b_valid} !== 4'b0) begin
      fails++; $display("FAIL mid_reset_r: got %b want 0000", {r_valid, r_last, ar_ready, b_valid});
    end
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({ar_ready, aw_ready} !== 2'b11) begin fails++; $display("FAIL mid_release: got %b want 11", {ar_ready, aw_ready}); end
    do_read(2'd3, 32'h100, 8'd3, 2'b01, 2);
    // abort a write burst the same way; strobe 0 leaves the RAM untouched
    aw_id = 2'd2; aw_addr = 32'h180; aw_len = 8'd3; aw_burst = 2'b01; aw_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b1; w_data = 32'h0; w_strb = 4'h0; w_last = 1'b0;
    @(posedge clk); @(negedge clk);
    w_valid = 1'b0; rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({w_ready, b_valid, aw_ready} !== 3'b0) begin
      fails++; $display("FAIL mid_reset_w: got %b want 000", {w_ready, b_valid, aw_ready});
    end
    rstn = 1'b1;
    @(posedge clk);
    wdat[0] = 32'h5A5A5A5A; wstb[0] = 4'hf;
    do_write(2'd2, 32'h180, 8'd0, 2'b01, 1);
    do_read(2'd2, 32'h180, 8'd0, 2'b01, 0);
  endtask

  task automatic test_random;
    logic [7:0] len; logic [1:0] burst; logic [31:0] addr; int word, nb;
    for (int it = 0; it < 40; it++) begin
      len   = 8'($urandom_range(7));
      burst = ($urandom_range(9) == 0) ? 2'(2 + $urandom_range(1)) : 2'($urandom_range(1));
      word  = int'($urandom_range(31 - int'(len)));
      addr  = 32'(word * 4) + 32'($urandom_range(3));
      if ($urandom_range(7) == 0) addr = addr + 32'h0001_0000;
      if ($urandom_range(1) == 1) begin
        nb = int'(len) + 1;
        if ($urandom_range(7) == 0) nb = int'($urandom_range(int'(len) + 2, 1));
        for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
        do_write(2'($urandom), addr, len, burst, nb);
      end else begin
        do_read(2'($urandom), addr, len, burst, int'($urandom_range(2)));
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 1'b0; r_ready = 1'b0;
    test_reset;
    test_fill;
    test_single;
    test_incr_toggle;
    test_partial_strobe;
    test_errors;
    test_early_last;
    test_same_cycle;
    test_reset_mid_burst;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
